// File: rtl/pe_d_pkg.sv
// ============================================================================
//  Module      : pe_d_pkg
//  Description : Shared constants and types for the pe_d_cell processing
//                element. Contains the configuration word field positions,
//                the ALU opcodes, the operand/crossbar source codes and the
//                register-file modes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_d_pkg;

    // Datapath and configuration word widths
    localparam int PE_DW = 32;
    localparam int PE_IW = 28;

    // Configuration word field positions (MSB first)
    localparam int ALU_OP_MSB  = 27;
    localparam int ALU_OP_LSB  = 24;
    localparam int OPA_MSB     = 23;
    localparam int OPA_LSB     = 21;
    localparam int OPB_MSB     = 20;
    localparam int OPB_LSB     = 18;
    localparam int NSEL_MSB    = 17;
    localparam int NSEL_LSB    = 15;
    localparam int WSEL_MSB    = 14;
    localparam int WSEL_LSB    = 12;
    localparam int SSEL_MSB    = 11;
    localparam int SSEL_LSB    = 9;
    localparam int ESEL_MSB    = 8;
    localparam int ESEL_LSB    = 6;
    localparam int RFMODE_MSB  = 5;
    localparam int RFMODE_LSB  = 4;
    localparam int RFIDX_MSB   = 3;
    localparam int RFIDX_LSB   = 2;
    localparam int RSVD_MSB    = 1;
    localparam int RSVD_LSB    = 0;

    // ALU opcodes; codes 9..15 produce zero
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_PASS = 4'd8;

    // Operand / crossbar source codes: input latches then register file
    typedef enum logic [2:0] {
        SRC_D0 = 3'd0,
        SRC_D1 = 3'd1,
        SRC_D2 = 3'd2,
        SRC_D3 = 3'd3,
        SRC_R0 = 3'd4,
        SRC_R1 = 3'd5,
        SRC_R2 = 3'd6,
        SRC_R3 = 3'd7
    } src_sel_e;

    // Register file update modes
    typedef enum logic [1:0] {
        RF_HOLD  = 2'd0,
        RF_SHIFT = 2'd1,
        RF_WRITE = 2'd2,
        RF_CLEAR = 2'd3
    } rf_mode_e;

    // Execution state of the PE
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pe_state_e;

    // Decoded configuration (reserved bits are not stored)
    typedef struct packed {
        logic [3:0] alu_op;
        src_sel_e   opa_sel;
        src_sel_e   opb_sel;
        src_sel_e   n_sel;
        src_sel_e   w_sel;
        src_sel_e   s_sel;
        src_sel_e   e_sel;
        rf_mode_e   rf_mode;
        logic [1:0] rf_idx;
    } pe_cfg_t;

endpackage

`default_nettype wire

// File: rtl/pe_d_alu.sv
// ============================================================================
//  Module      : pe_d_alu
//  Description : Purely combinational ALU of the processing element.
//                All arithmetic wraps modulo 2^DW; shifts use the low
//                log2(DW) bits of B; undefined opcodes yield zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_d_alu
    import pe_d_pkg::*;
#(
    parameter int DW = PE_DW
) (
    input  logic [3:0]    alu_op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res
);

    localparam int SHW = $clog2(DW);

    // Opcode decode into a single result
    always_comb begin
        res = '0;
        case (alu_op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_MUL:  res = a * b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SHL:  res = a << b[SHW-1:0];
            ALU_SHR:  res = a >> b[SHW-1:0];
            ALU_PASS: res = a;
            default:  res = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pe_d_cell.sv
// ============================================================================
//  Module      : pe_d_cell
//  Description : Single processing element of the reconfigurable array.
//                Latches a configuration word on init, runs after a run
//                pulse: each running cycle it latches the four neighbour
//                inputs, computes one ALU result, updates a 4-entry register
//                file and drives four neighbour outputs via a crossbar.
//                Optional macro PE_D_OUT_REG_EN registers the four outputs
//                (one extra cycle of latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_d_cell
    import pe_d_pkg::*;
#(
    parameter int DW = PE_DW,
    parameter int IW = PE_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] PE_inst,
    input  logic          init,
    input  logic          run,
    input  logic [DW-1:0] din_N,
    input  logic [DW-1:0] din_W,
    input  logic [DW-1:0] din_S,
    input  logic [DW-1:0] din_E,
    output logic [DW-1:0] dout_N,
    output logic [DW-1:0] dout_S,
    output logic [DW-1:0] dout_W,
    output logic [DW-1:0] dout_E
);

    pe_state_e     state;
    pe_cfg_t       cfg;
    pe_cfg_t       cfg_next;
    logic [DW-1:0] d_reg   [4];
    logic [DW-1:0] rf      [4];
    logic [DW-1:0] din_v   [4];
    logic [DW-1:0] srcs    [8];
    src_sel_e      out_sel [4];
    logic [DW-1:0] out_mux [4];
    logic [DW-1:0] dout_v  [4];
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] res;
    logic          running;
    logic          unused_rsvd;

    // The two low configuration bits carry no function
    assign unused_rsvd = ^PE_inst[RSVD_MSB:RSVD_LSB];

    assign running = (state == ST_RUN);

    // Neighbour inputs in d0..d3 order: N, W, S, E
    assign din_v[0] = din_N;
    assign din_v[1] = din_W;
    assign din_v[2] = din_S;
    assign din_v[3] = din_E;

    // Split the incoming configuration word into its fields
    always_comb begin
        cfg_next         = '0;
        cfg_next.alu_op  = PE_inst[ALU_OP_MSB:ALU_OP_LSB];
        cfg_next.opa_sel = src_sel_e'(PE_inst[OPA_MSB:OPA_LSB]);
        cfg_next.opb_sel = src_sel_e'(PE_inst[OPB_MSB:OPB_LSB]);
        cfg_next.n_sel   = src_sel_e'(PE_inst[NSEL_MSB:NSEL_LSB]);
        cfg_next.w_sel   = src_sel_e'(PE_inst[WSEL_MSB:WSEL_LSB]);
        cfg_next.s_sel   = src_sel_e'(PE_inst[SSEL_MSB:SSEL_LSB]);
        cfg_next.e_sel   = src_sel_e'(PE_inst[ESEL_MSB:ESEL_LSB]);
        cfg_next.rf_mode = rf_mode_e'(PE_inst[RFMODE_MSB:RFMODE_LSB]);
        cfg_next.rf_idx  = PE_inst[RFIDX_MSB:RFIDX_LSB];
    end

    // Control: config load and run state; init always wins over run
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cfg   <= '0;
        end else if (init) begin
            state <= ST_IDLE;
            cfg   <= cfg_next;
        end else begin
            case (state)
                ST_IDLE: if (run) state <= ST_RUN;
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Source table shared by the ALU operand muxes and the output crossbar
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_src
            assign srcs[gi]     = d_reg[gi];
            assign srcs[gi + 4] = rf[gi];
        end
    endgenerate

    assign op_a = srcs[cfg.opa_sel];
    assign op_b = srcs[cfg.opb_sel];

    pe_d_alu #(
        .DW (DW)
    ) u_alu (
        .alu_op (cfg.alu_op),
        .a      (op_a),
        .b      (op_b),
        .res    (res)
    );

    // Datapath: input latches and register file advance only while running
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                d_reg[i] <= '0;
                rf[i]    <= '0;
            end
        end else if (!init && running) begin
            for (int i = 0; i < 4; i++) begin
                d_reg[i] <= din_v[i];
            end
            case (cfg.rf_mode)
                RF_SHIFT: begin
                    rf[0] <= res;
                    rf[1] <= rf[0];
                    rf[2] <= rf[1];
                    rf[3] <= rf[2];
                end
                RF_WRITE: rf[cfg.rf_idx] <= res;
                RF_CLEAR: begin
                    for (int i = 0; i < 4; i++) begin
                        rf[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Crossbar selects in N, W, S, E order
    assign out_sel[0] = cfg.n_sel;
    assign out_sel[1] = cfg.w_sel;
    assign out_sel[2] = cfg.s_sel;
    assign out_sel[3] = cfg.e_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_xbar
            assign out_mux[gi] = running ? srcs[out_sel[gi]] : '0;
        end
    endgenerate

`ifdef PE_D_OUT_REG_EN
    logic [DW-1:0] out_reg [4];

    // Output stage: one register per neighbour output
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                out_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                out_reg[i] <= out_mux[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out_reg
            assign dout_v[gi] = running ? out_reg[gi] : '0;
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out_comb
            assign dout_v[gi] = out_mux[gi];
        end
    endgenerate
`endif

    assign dout_N = dout_v[0];
    assign dout_W = dout_v[1];
    assign dout_S = dout_v[2];
    assign dout_E = dout_v[3];

endmodule

`default_nettype wire

// File: tb/tb_pe_d_cell.sv
// ============================================================================
//  Module      : tb_pe_d_cell
//  Description : Directed self-checking bench for pe_d_cell (default build,
//                combinational outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_d_cell;

    logic        clk;
    logic        rst;
    logic [27:0] PE_inst;
    logic        init;
    logic        run;
    logic [31:0] din_N, din_W, din_S, din_E;
    logic [31:0] dout_N, dout_S, dout_W, dout_E;

    int n_checks;
    int n_errors;

    pe_d_cell u_dut (
        .clk     (clk),
        .rst     (rst),
        .PE_inst (PE_inst),
        .init    (init),
        .run     (run),
        .din_N   (din_N),
        .din_W   (din_W),
        .din_S   (din_S),
        .din_E   (din_E),
        .dout_N  (dout_N),
        .dout_S  (dout_S),
        .dout_W  (dout_W),
        .dout_E  (dout_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] mk(input int op, input int a, input int b,
                                       input int n, input int w, input int s,
                                       input int e, input int mode, input int idx);
        logic [27:0] word;
        word = {op[3:0], a[2:0], b[2:0], n[2:0], w[2:0], s[2:0], e[2:0],
                mode[1:0], idx[1:0], 2'b00};
        return word;
    endfunction

    task automatic load_and_run(input logic [27:0] word);
        PE_inst = word;
        init = 1'b1;
        step();
        init = 1'b0;
        run  = 1'b1;
        step();
        run  = 1'b0;
    endtask

    int          alu_ops  [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12};
    logic [31:0] alu_exps [10] = '{32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFE,
                                   32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                   32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'hFFFF_FFFF,
                                   32'h0000_0000};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst     = 1'b0;
        init    = 1'b0;
        run     = 1'b0;
        PE_inst = 28'h0041DD0;
        din_N   = 32'h1111_1111;
        din_W   = 32'h2222_2222;
        din_S   = 32'h3333_3333;
        din_E   = 32'h4444_4444;

        // Reset
        step();
        step();
        check_val("rst_N", dout_N, 32'h0);
        check_val("rst_W", dout_W, 32'h0);
        check_val("rst_S", dout_S, 32'h0);
        check_val("rst_E", dout_E, 32'h0);
        rst = 1'b1;
        step();
        step();
        check_val("idle_N", dout_N, 32'h0);

        // Pass-through and pipeline latency
        load_and_run(28'h0041DD0);
        din_N = 32'd10;
        din_W = 32'd20;
        step();
        check_val("pipe_N_e1", dout_N, 32'd10);
        check_val("pipe_W_e1", dout_W, 32'd20);
        step();
        step();
        check_val("pipe_S_e3", dout_S, 32'd0);
        step();
        check_val("pipe_S_e4", dout_S, 32'd30);
        check_val("pipe_E_e4", dout_E, 32'd0);
        step();
        check_val("pipe_E_e5", dout_E, 32'd30);

        // Incrementing stream: dout_S trails dout_N by three cycles
        load_and_run(28'h0041DD0);
        for (int j = 1; j <= 7; j++) begin
            din_N = 32'(2 + j);
            din_W = 32'(3 + j);
            step();
            if (j >= 4) begin
                check_val("stream_N", dout_N, 32'(2 + j));
                check_val("stream_S", dout_S, 32'(2 * j - 1));
            end
        end

        // ALU operations with A=0xFFFFFFFF, B=2, result written to R0
        for (int k = 0; k < 10; k++) begin
            load_and_run(mk(alu_ops[k], 0, 1, 4, 1, 0, 0, 2, 0));
            din_N = 32'hFFFF_FFFF;
            din_W = 32'd2;
            step();
            step();
            check_val($sformatf("alu_op%0d", alu_ops[k]), dout_N, alu_exps[k]);
        end
        check_val("alu_W_d1", dout_W, 32'd2);

        // init and run together: run ignored, outputs stay zero
        PE_inst = mk(0, 0, 1, 0, 1, 0, 0, 1, 0);
        init = 1'b1;
        run  = 1'b1;
        step();
        init = 1'b0;
        run  = 1'b0;
        step();
        step();
        check_val("prio_N", dout_N, 32'h0);

        // init while running halts updates and keeps d/R
        load_and_run(mk(0, 0, 1, 4, 5, 0, 1, 1, 0));
        din_N = 32'd5;
        din_W = 32'd6;
        step();
        step();
        check_val("halt_pre_N", dout_N, 32'd11);
        check_val("halt_pre_W", dout_W, 32'd1);
        init  = 1'b1;
        din_N = 32'd100;
        step();
        init = 1'b0;
        check_val("halt_N_zero", dout_N, 32'h0);
        run = 1'b1;
        step();
        run = 1'b0;
        check_val("halt_R0_kept", dout_N, 32'd11);
        check_val("halt_R1_kept", dout_W, 32'd1);
        check_val("halt_d0_kept", dout_S, 32'd5);
        step();
        check_val("resume_d0", dout_S, 32'd100);

        // Register-file clear
        load_and_run(mk(0, 0, 1, 4, 5, 6, 7, 3, 0));
        check_val("clr_pre_N", dout_N, 32'd11);
        step();
        check_val("clr_R0", dout_N, 32'h0);
        check_val("clr_R1", dout_W, 32'h0);
        check_val("clr_R2", dout_S, 32'h0);
        check_val("clr_R3", dout_E, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pe_d_cell.md
Name: pe_d_cell

Overview:
- Single processing element (PE) of the coarse-grained reconfigurable array.
- A 28-bit configuration word is latched on `init`; `run` starts execution.
- Each cycle while running, the PE does the following:
  - latches its four neighbour inputs;
  - computes one ALU result from two selected operands;
  - pushes the result into a 4-entry register file;
  - drives each of its four neighbour outputs from a configurable crossbar.

Parameters:
- DW, 32, datapath width of every din/dout and register.
- IW, 28, configuration word width (fixed format below; not meant to be changed).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next clk edge).
- PE_inst  in  28  configuration word, sampled when init==1.
- init  in  1  load PE_inst into the config register; stop running.
- run  in  1  one-cycle start pulse; PE runs until the next init or reset.
- din_N / din_W / din_S / din_E  in  32 each  neighbour inputs.
- dout_N / dout_S / dout_W / dout_E  out  32 each  neighbour outputs.

Behaviour:
- Config fields (MSB first), per PE_inst bit range:
  - [27:24] alu_op
  - [23:21] opA_sel
  - [20:18] opB_sel
  - [17:15] N_sel
  - [14:12] W_sel
  - [11:9] S_sel
  - [8:6] E_sel
  - [5:4] rf_mode
  - [3:2] rf_idx
  - [1:0] reserved, ignored
- 3-bit source codes (all selects): 0=d0, 1=d1, 2=d2, 3=d3, 4=R0, 5=R1, 6=R2, 7=R3.
  - d0..d3 are the input latches of din_N, din_W, din_S, din_E respectively.
- alu_op codes (result = res, 32 bits, wraps modulo 2^32):
  - 0 ADD, 1 SUB (A-B), 2 MUL (low 32 bits), 3 AND, 4 OR, 5 XOR
  - 6 SHL A by B[4:0], 7 SHR logical A by B[4:0], 8 PASS A
  - 9..15 → res=0
- rf_mode:
  - 0 hold
  - 1 shift chain: R0<=res, R1<=R0, R2<=R1, R3<=R2
  - 2 R[rf_idx]<=res only
  - 3 clear R0..R3 to 0
- Reset (rst==0 at an edge): config=0, running=0, d0..d3=0, R0..R3=0, all dout=0.
- init==1 at an edge:
  - config<=PE_inst and running<=0;
  - d and R hold their values;
  - init has priority over a simultaneous run (that run is ignored).
- run==1 with init==0 at an edge: running<=1.
  - The first data update happens on the following edge.
  - A run while already running has no effect.
- Each edge with running==1:
  - d0..d3 <= din_N, din_W, din_S, din_E;
  - the register file updates per rf_mode, using res computed combinationally from the pre-edge d/R values.
- While running==0, d and R hold.
- Outputs:
  - dout_X = source selected by X_sel, combinational from registered d/R state (no combinational input-to-output path);
  - forced to 0 while running==0.
- Latency, rf_mode=1:
  - din sampled at edge k appears on a d-selected output after edge k;
  - its sum lands in R0 after k+1, R1 after k+2, R2 after k+3, R3 after k+4.

Optional Feature:
- PE_D_OUT_REG_EN:
  - When defined, all four douts are registered: one extra cycle latency, reset to 0, zero while not running.
  - When undefined, the outputs are combinational from state as above.

Decomposition:
- Shared package pe_d_pkg holds:
  - field bit positions;
  - alu_op codes;
  - source-select codes;
  - rf_mode codes;
  - DW/IW constants.
- One natural sub-module: pe_d_alu (purely combinational; inputs alu_op, A, B; output res).

Test Plan:
- Reset: hold rst=0 for 2 edges with nonzero din → all dout=0; after release, dout stays 0 until running.
- Pass-through and pipeline: init with PE_inst=28'h0041DD0, then run, then hold din_N=10, din_W=20 → after the first running edge dout_N=10, dout_W=20; dout_S=30 after the 4th running edge; dout_E=30 after the 5th.
  - This word encodes ADD; A=d0, B=d1; N=d0, W=d1, S=R2, E=R3; shift chain.
- Incrementing stream: din_N=3,4,5…, din_W=4,5,6… per cycle under the same config → dout_S sequence 7, 9, 11…, lagging dout_N by 3 cycles.
- ALU ops: A=d0=0xFFFFFFFF, B=d1=2 with rf_mode=2, rf_idx=0, N_sel=R0:
  - ADD → 1; SUB → 0xFFFFFFFD; MUL → 0xFFFFFFFE; SHL → 0xFFFFFFFC; SHR → 0x3FFFFFFF; op 12 → 0.
- Init priority: assert init and run in the same cycle → running stays 0 and outputs stay 0; a subsequent init while running stops updates with R values retained.
- rf_mode=3 while running → R0..R3 read 0 on the next cycle.
